// File: rtl/uart_receiver.sv
// 8N1 UART receiver: synchronizes the serial line, samples each bit at mid-bit
// and emits framed bytes with a one-cycle valid strobe or a framing-error strobe.
module uart_receiver #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       i_reset,
  input  logic       i_rx,
  output logic [7:0] o_data,
  output logic       o_valid,
  output logic       o_frame_err,
  output logic       o_busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF = CNT_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } state_t;

  state_t           state, state_next;
  logic             rx_meta, rx_s;
  logic [CNT_W-1:0] count, count_next;
  logic [2:0]       bit_idx, bit_idx_next;
  logic [7:0]       shift_reg, shift_next;
  logic [7:0]       data_next;
  logic             valid_next, frame_err_next;

  // Flops reset high so a reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (i_reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= i_rx;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (i_reset) begin
      state       <= IDLE;
      count       <= '0;
      bit_idx     <= '0;
      shift_reg   <= '0;
      o_data      <= '0;
      o_valid     <= 1'b0;
      o_frame_err <= 1'b0;
    end else begin
      state       <= state_next;
      count       <= count_next;
      bit_idx     <= bit_idx_next;
      shift_reg   <= shift_next;
      o_data      <= data_next;
      o_valid     <= valid_next;
      o_frame_err <= frame_err_next;
    end
  end

  always_comb begin
    state_next     = state;
    count_next     = count + CNT_W'(1);
    bit_idx_next   = bit_idx;
    shift_next     = shift_reg;
    data_next      = o_data;
    valid_next     = 1'b0;
    frame_err_next = 1'b0;

    case (state)
      IDLE: begin
        count_next = '0;
        if (!rx_s) state_next = START;
      end
      START: begin
        bit_idx_next = '0;
        if (count == HALF) state_next = rx_s ? IDLE : DATA;
      end
      DATA: begin
        if (count == LAST) begin
          shift_next   = {rx_s, shift_reg[7:1]};
          bit_idx_next = bit_idx + 3'd1;
          count_next   = '0;
          if (bit_idx == 3'd7) state_next = STOP;
        end
      end
      STOP: begin
        if (count == LAST) begin
          if (rx_s) begin
            data_next  = shift_reg;
            valid_next = 1'b1;
            state_next = IDLE;
          end else begin
            frame_err_next = 1'b1;
            state_next     = BREAK;
          end
        end
      end
      BREAK: begin
        // A held-low line must rise before another frame is considered.
        count_next = '0;
        if (rx_s) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    if (state_next != state) count_next = '0;
  end

  assign o_busy = (state != IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// Directed testbench for uart_receiver at 16 clocks per bit; a negedge monitor
// logs strobes and busy cycles, and the main sequence asserts on them.
module tb_uart_receiver;

  localparam int CPB = 16;

  logic       clk;
  logic       i_reset;
  logic       i_rx;
  logic [7:0] o_data;
  logic       o_valid;
  logic       o_frame_err;
  logic       o_busy;

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;

  int         valid_cyc[$];
  logic [7:0] valid_dat[$];
  int         err_cyc[$];
  int         busy_cnt  = 0;
  int         overlap   = 0;
  int         stretch   = 0;
  logic       prev_valid = 1'b0;
  logic       prev_err   = 1'b0;

  uart_receiver #(.CLKS_PER_BIT(CPB)) dut (
    .clk         (clk),
    .i_reset     (i_reset),
    .i_rx        (i_rx),
    .o_data      (o_data),
    .o_valid     (o_valid),
    .o_frame_err (o_frame_err),
    .o_busy      (o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Strobes and busy are logged on the falling edge, tagged with the cycle index.
  always @(negedge clk) begin
    if (o_valid === 1'b1) begin
      valid_cyc.push_back(cyc);
      valid_dat.push_back(o_data);
    end
    if (o_frame_err === 1'b1) err_cyc.push_back(cyc);
    if (o_valid === 1'b1 && o_frame_err === 1'b1) overlap++;
    if ((o_valid === 1'b1 && prev_valid) || (o_frame_err === 1'b1 && prev_err)) stretch++;
    prev_valid = (o_valid === 1'b1);
    prev_err   = (o_frame_err === 1'b1);
    if (o_busy === 1'b1) busy_cnt++;
  end

  function automatic int get_vcyc(input int idx);
    return (idx < valid_cyc.size()) ? valid_cyc[idx] : -1;
  endfunction

  function automatic logic [7:0] get_vdat(input int idx);
    return (idx < valid_dat.size()) ? valid_dat[idx] : 8'hxx;
  endfunction

  function automatic int get_ecyc(input int idx);
    return (idx < err_cyc.size()) ? err_cyc[idx] : -1;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    valid_cyc.delete();
    valid_dat.delete();
    err_cyc.delete();
    busy_cnt = 0;
  endtask

  task automatic send_bit(input logic b);
    i_rx = b;
    wait_cycles(CPB);
  endtask

  // Drives one full frame: start bit, eight data bits LSB-first, stop bit.
  task automatic applyStimulus(input logic [7:0] data, input logic stop_bit);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(data[i]);
    send_bit(stop_bit);
  endtask

  int e;
  int r;

  initial begin
    i_reset = 1'b1;
    i_rx    = 1'b1;
    wait_cycles(3);
    i_reset = 1'b0;
    checkOutput("reset_data",  {24'd0, o_data}, 32'h00);
    checkOutput("reset_valid", {31'd0, o_valid}, 32'd0);
    checkOutput("reset_ferr",  {31'd0, o_frame_err}, 32'd0);
    checkOutput("reset_busy",  {31'd0, o_busy}, 32'd0);
    clear_log();
    wait_cycles(200);
    checkOutput("idle_valid_cnt", valid_cyc.size(), 0);
    checkOutput("idle_ferr_cnt",  err_cyc.size(), 0);
    checkOutput("idle_busy_cnt",  busy_cnt, 0);

    // Single frame 0xA5
    clear_log();
    e = cyc;
    applyStimulus(8'hA5, 1'b1);
    checkOutput("a5_valid_cnt", valid_cyc.size(), 1);
    checkOutput("a5_valid_cyc", get_vcyc(0), e + 155);
    checkOutput("a5_valid_dat", {24'd0, get_vdat(0)}, 32'hA5);
    checkOutput("a5_busy_cycles", busy_cnt, 152);
    checkOutput("a5_o_data", {24'd0, o_data}, 32'hA5);
    wait_cycles(20);

    // Back-to-back 0x00, 0xFF, 0x81
    clear_log();
    e = cyc;
    applyStimulus(8'h00, 1'b1);
    applyStimulus(8'hFF, 1'b1);
    applyStimulus(8'h81, 1'b1);
    checkOutput("b2b_valid_cnt", valid_cyc.size(), 3);
    checkOutput("b2b_cyc0", get_vcyc(0), e + 155);
    checkOutput("b2b_cyc1", get_vcyc(1), e + 315);
    checkOutput("b2b_cyc2", get_vcyc(2), e + 475);
    checkOutput("b2b_dat0", {24'd0, get_vdat(0)}, 32'h00);
    checkOutput("b2b_dat1", {24'd0, get_vdat(1)}, 32'hFF);
    checkOutput("b2b_dat2", {24'd0, get_vdat(2)}, 32'h81);
    checkOutput("b2b_ferr_cnt", err_cyc.size(), 0);
    wait_cycles(20);

    // Glitch of 5 cycles
    clear_log();
    i_rx = 1'b0;
    wait_cycles(5);
    checkOutput("glitch_busy_hi", {31'd0, o_busy}, 32'd1);
    i_rx = 1'b1;
    wait_cycles(30);
    checkOutput("glitch_busy_lo", {31'd0, o_busy}, 32'd0);
    checkOutput("glitch_busy_cycles", busy_cnt, 8);
    checkOutput("glitch_valid_cnt", valid_cyc.size(), 0);
    checkOutput("glitch_ferr_cnt", err_cyc.size(), 0);
    checkOutput("glitch_o_data", {24'd0, o_data}, 32'h81);

    // Framing error followed by a break
    applyStimulus(8'h5A, 1'b1);
    wait_cycles(10);
    checkOutput("pre_ferr_data", {24'd0, o_data}, 32'h5A);
    clear_log();
    e = cyc;
    applyStimulus(8'h3C, 1'b0);
    wait_cycles(100);
    checkOutput("ferr_cnt", err_cyc.size(), 1);
    checkOutput("ferr_cyc", get_ecyc(0), e + 155);
    checkOutput("ferr_valid_cnt", valid_cyc.size(), 0);
    checkOutput("ferr_o_data", {24'd0, o_data}, 32'h5A);
    checkOutput("break_busy", {31'd0, o_busy}, 32'd1);
    r = cyc;
    i_rx = 1'b1;
    wait_cycles(10);
    checkOutput("break_release_busy", {31'd0, o_busy}, 32'd0);
    checkOutput("break_busy_cycles", busy_cnt, r - e);
    clear_log();
    e = cyc;
    applyStimulus(8'hC3, 1'b1);
    checkOutput("after_break_cyc", get_vcyc(0), e + 155);
    checkOutput("after_break_data", {24'd0, o_data}, 32'hC3);
    wait_cycles(20);

    // Reset in the middle of 0x77
    clear_log();
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'(8'h77 >> i));
    checkOutput("mid_busy_before", {31'd0, o_busy}, 32'd1);
    i_reset = 1'b1;
    i_rx    = 1'b1;
    wait_cycles(1);
    i_reset = 1'b0;
    checkOutput("midrst_busy", {31'd0, o_busy}, 32'd0);
    checkOutput("midrst_data", {24'd0, o_data}, 32'h00);
    wait_cycles(200);
    checkOutput("midrst_valid_cnt", valid_cyc.size(), 0);
    checkOutput("midrst_ferr_cnt", err_cyc.size(), 0);
    clear_log();
    e = cyc;
    applyStimulus(8'h12, 1'b1);
    checkOutput("post_rst_cnt", valid_cyc.size(), 1);
    checkOutput("post_rst_cyc", get_vcyc(0), e + 155);
    checkOutput("post_rst_data", {24'd0, o_data}, 32'h12);
    wait_cycles(10);

    checkOutput("strobe_overlap", overlap, 0);
    checkOutput("strobe_stretch", stretch, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
